mem_access_ctrl: RTL and testbench

- Multi-cycle sequencer for MIPS load/store instructions (lw opcode 6'b100011, sw opcode 6'b101011).
- Accepts one instruction at a time and drives the register-file read addresses.
- Forms the effective address as base + sign-extended imm16 (ALU add).
- Runs a request/ready handshake with data memory and, for lw, writes the result back to the register file.
- Sits between the instruction fetch/issue stage and the shared register file / data memory.

---
 rtl/mem_access_ctrl.sv | 152 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store sequencer: decodes lw/sw, forms base+imm address,
// runs the data-memory request/ready handshake and writes load data back.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] instruction,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        reg_write,
    output logic [4:0]  reg_waddr,
    output logic [31:0] reg_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_SW       = 6'b101011;
    localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_ADDR, S_MEM, S_WB, S_FIN, S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] rs_data_q, rs_data_d;
    logic [31:0] rt_data_q, rt_data_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] reg_wdata_q, reg_wdata_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic [5:0]  opcode;
    logic [31:0] eff_addr;
    logic [7:0]  wait_inc;

    assign opcode   = instr_q[31:26];
    assign eff_addr = rs_data_q + {{16{instr_q[15]}}, instr_q[15:0]};
    assign wait_inc = wait_cnt_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        reg_wdata_d = reg_wdata_q;
        err_code_d  = err_code_q;
        wait_cnt_d  = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    instr_d    = instruction;
                    err_code_d = 2'd0;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                rs_data_d = read_data1;
                rt_data_d = read_data2;
                state_d   = S_ADDR;
            end
            S_ADDR: begin
                mem_addr_d  = eff_addr;
                mem_wdata_d = rt_data_q;
                wait_cnt_d  = 8'd0;
                // Illegal opcode takes priority over a misaligned address.
                if (opcode != OP_LW && opcode != OP_SW) begin
                    err_code_d = 2'd1;
                    state_d    = S_ERR;
                end else if (eff_addr[1:0] != 2'b00) begin
                    err_code_d = 2'd2;
                    state_d    = S_ERR;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_MEM: begin
                // Ready on the same edge the counter expires still completes.
                if (mem_ready) begin
                    if (opcode == OP_LW) begin
                        reg_wdata_d = mem_rdata;
                        state_d     = S_WB;
                    end else begin
                        state_d = S_FIN;
                    end
                end else begin
                    wait_cnt_d = wait_inc;
                    if (wait_inc == TIMEOUT_CNT) begin
                        err_code_d = 2'd3;
                        state_d    = S_ERR;
                    end
                end
            end
            S_WB, S_FIN, S_ERR: state_d = S_IDLE;
            default:            state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            instr_q     <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            reg_wdata_q <= '0;
            err_code_q  <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            reg_wdata_q <= reg_wdata_d;
            err_code_q  <= err_code_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign rs_addr   = instr_q[25:21];
    assign rt_addr   = instr_q[20:16];
    assign reg_waddr = instr_q[20:16];
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign reg_wdata = reg_wdata_q;
    assign err_code  = err_code_q;
    assign mem_read  = (state_q == S_MEM) && (opcode == OP_LW);
    assign mem_write = (state_q == S_MEM) && (opcode == OP_SW);
    assign reg_write = (state_q == S_WB) && (instr_q[20:16] != 5'd0);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_WB) || (state_q == S_FIN);
    assign error     = (state_q == S_ERR);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Table-driven bench for mem_access_ctrl with a scoreboard queue of expected
// completions, plus hand-written reset-in-MEM and busy-start sequences.
module tb_mem_access_ctrl;
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] instruction;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] read_data1, read_data2;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        reg_write;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        busy, done, error;
    logic [1:0]  err_code;

    logic [31:0] rf [32];
    int checks = 0;
    int failures = 0;

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .start(start), .instruction(instruction),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .read_data1(read_data1), .read_data2(read_data2),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .reg_write(reg_write), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always_comb begin
        read_data1 = rf[rs_addr];
        read_data2 = rf[rt_addr];
    end

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] rdata;
        int          delay;      // wait cycles before ready; -1 = never
        int          exp_cycle;  // cycle of done/error, accept edge = 0
        logic        exp_done;
        logic [1:0]  exp_code;
        logic [31:0] exp_addr;
        int          exp_req;    // number of request cycles
        logic        exp_regw;
        logic [31:0] exp_wb;
    } vec_t;

    vec_t tbl [8];
    vec_t sb [$];

    function automatic vec_t mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [15:0] imm, input logic [31:0] rs_val,
                                input logic [31:0] rt_val, input logic [31:0] rdata,
                                input int delay, input int exp_cycle, input logic exp_done,
                                input logic [1:0] exp_code, input logic [31:0] exp_addr,
                                input int exp_req, input logic exp_regw, input logic [31:0] exp_wb);
        vec_t v;
        v.op = op; v.rs = rs; v.rt = rt; v.imm = imm; v.rs_val = rs_val; v.rt_val = rt_val;
        v.rdata = rdata; v.delay = delay; v.exp_cycle = exp_cycle; v.exp_done = exp_done;
        v.exp_code = exp_code; v.exp_addr = exp_addr; v.exp_req = exp_req;
        v.exp_regw = exp_regw; v.exp_wb = exp_wb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 30) begin
            @(posedge clk); @(negedge clk); n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run_txn(input int idx, input vec_t v, input bit poke);
        int cyc, rd, wr, end_cyc;
        bit both, fin, regw_seen, done_seen, err_seen;
        logic [31:0] addr_seen, wd_seen, wb_seen;
        logic [4:0]  waddr_seen;
        logic [1:0]  code_seen;
        vec_t e;
        wait_idle();
        rf[v.rs] = v.rs_val;
        rf[v.rt] = v.rt_val;
        start = 1'b1;
        instruction = {v.op, v.rs, v.rt, v.imm};
        sb.push_back(v);
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        instruction = 32'hFFFF_FFFF;
        cyc = 1; rd = 0; wr = 0; end_cyc = 0; both = 0; fin = 0;
        regw_seen = 0; done_seen = 0; err_seen = 0;
        addr_seen = '0; wd_seen = '0; wb_seen = '0; waddr_seen = '0; code_seen = '0;
        while (!fin && cyc < 30) begin
            mem_ready = 1'b0;
            // A start offered while busy must be ignored.
            if (poke && cyc == 2) begin
                start = 1'b1;
                instruction = {OP_SW, 5'd1, 5'd2, 16'h0040};
            end else if (poke && cyc == 3) begin
                start = 1'b0;
            end
            if (mem_read && mem_write) both = 1;
            if (mem_read) rd++;
            if (mem_write) wr++;
            if (mem_read || mem_write) begin
                addr_seen = mem_addr;
                wd_seen = mem_wdata;
                if (v.delay >= 0 && rd + wr == v.delay + 1) begin
                    mem_ready = 1'b1;
                    mem_rdata = v.rdata;
                end
            end
            if (reg_write) begin
                regw_seen = 1; waddr_seen = reg_waddr; wb_seen = reg_wdata;
            end
            if (done || error) begin
                fin = 1; done_seen = done; err_seen = error; code_seen = err_code; end_cyc = cyc;
            end else begin
                @(posedge clk); @(negedge clk); cyc++;
            end
        end
        mem_ready = 1'b0;
        start = 1'b0;
        if (!fin) chk("completion_timeout", 32'(fin), 32'd1);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        chk("end_cycle", 32'(end_cyc), 32'(e.exp_cycle));
        chk("done", 32'(done_seen), 32'(e.exp_done));
        chk("error", 32'(err_seen), 32'(!e.exp_done));
        chk("err_code", 32'(code_seen), 32'(e.exp_code));
        chk("both_req", 32'(both), 32'd0);
        chk("read_cycles", 32'(rd), (e.op == OP_LW) ? 32'(e.exp_req) : 32'd0);
        chk("write_cycles", 32'(wr), (e.op == OP_SW) ? 32'(e.exp_req) : 32'd0);
        chk("reg_write", 32'(regw_seen), 32'(e.exp_regw));
        if (e.exp_req > 0) begin
            chk("mem_addr", addr_seen, e.exp_addr);
            chk("mem_wdata", wd_seen, e.rt_val);
        end
        if (e.exp_regw) begin
            chk("reg_waddr", 32'(waddr_seen), 32'(e.rt));
            chk("reg_wdata", wb_seen, e.exp_wb);
        end
        @(posedge clk); @(negedge clk);
        chk("busy_after", 32'(busy), 32'd0);
        $display("txn %0d op=%02h done=%0b error=%0b code=%0d cycle=%0d req=%0d", idx, v.op,
                 done_seen, err_seen, code_seen, end_cyc, rd + wr);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        reset = 1'b0; start = 1'b0; instruction = '0; mem_rdata = '0; mem_ready = 1'b0;

        //          op     rs    rt     imm       rs_val        rt_val        rdata         dly cyc done code addr          req regw wb
        tbl[0] = mk(OP_SW, 5'd1, 5'd2,  16'h0008, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,         0, 4, 1, 2'd0, 32'h0000_1008, 1, 0, 32'h0);
        tbl[1] = mk(OP_LW, 5'd3, 5'd9,  16'hFFFC, 32'h0000_2000, 32'h0000_0077, 32'h1234_5678, 3, 7, 1, 2'd0, 32'h0000_1FFC, 4, 1, 32'h1234_5678);
        tbl[2] = mk(OP_LW, 5'd4, 5'd5,  16'h0000, 32'h0000_1001, 32'h0000_0055, 32'h0,         0, 3, 0, 2'd2, 32'h0,         0, 0, 32'h0);
        tbl[3] = mk(6'h00, 5'd4, 5'd5,  16'h0000, 32'h0000_1001, 32'h0000_0055, 32'h0,         0, 3, 0, 2'd1, 32'h0,         0, 0, 32'h0);
        tbl[4] = mk(OP_LW, 5'd6, 5'd0,  16'h0004, 32'h0000_0040, 32'h0000_0000, 32'h0000_CAFE, 0, 4, 1, 2'd0, 32'h0000_0044, 1, 0, 32'h0);
        tbl[5] = mk(OP_LW, 5'd7, 5'd8,  16'h0000, 32'h0000_0080, 32'h0000_0011, 32'h0,        -1, 7, 0, 2'd3, 32'h0000_0080, 4, 0, 32'h0);
        tbl[6] = mk(OP_SW, 5'd10, 5'd11, 16'h0008, 32'hFFFF_FFFC, 32'h0BAD_F00D, 32'h0,        3, 7, 1, 2'd0, 32'h0000_0004, 4, 0, 32'h0);
        tbl[7] = mk(OP_LW, 5'd13, 5'd12, 16'hFFF0, 32'h0000_0000, 32'h0000_0022, 32'hA5A5_5A5A, 1, 5, 1, 2'd0, 32'hFFFF_FFF0, 2, 1, 32'hA5A5_5A5A);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_err", {30'd0, done, error}, 32'd0);
        chk("rst_req", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_txn(i, tbl[i], (i == 1));

        // Reset during MEM of a store: request dropped, no done/error.
        rf[1] = 32'h0000_3000; rf[2] = 32'h1111_2222;
        start = 1'b1;
        instruction = {OP_SW, 5'd1, 5'd2, 16'h0000};
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!mem_write && n < 10) begin
            @(posedge clk); @(negedge clk); n++;
        end
        chk("rst_seq_in_mem", 32'(mem_write), 32'd1);
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done_err", {30'd0, done, error}, 32'd0);
        chk("midrst_req", {30'd0, mem_read, mem_write}, 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        chk("midrst_mem_wdata", mem_wdata, 32'd0);
        chk("midrst_err_code", 32'(err_code), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        $display("txn reset_in_mem busy=%0b done=%0b error=%0b", busy, done, error);

        run_txn(8, tbl[0], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "global timeout");
    end
endmodule
